// File: rtl/button_pkg.sv
// Shared constants for the push-button front end: FSM encoding, idle pin level
// and the default debounce interval.
package button_pkg;

    localparam logic [1:0] ST_REL        = 2'd0;
    localparam logic [1:0] ST_PEND_PRESS = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_PEND_REL   = 2'd3;

    localparam logic BTN_IDLE_LEVEL = 1'b1;

    // 20 ms at 50 MHz
    localparam int unsigned BTN_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/button_sync.sv
// N-stage synchronizer for an asynchronous input; resets to the idle
// (released) pin level so no false press is seen out of reset.
module button_sync
    import button_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{BTN_IDLE_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push-button pin into a clean level, with registered
// press/release strobes and a saturating count of aborted transitions.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_raw,
    input  logic       glitch_clr,
    output logic       button_clean,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_out;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic [7:0]       glitch_q, glitch_d;
    logic             abort;

    button_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(reset),
        .d    (button_raw),
        .q    (sync_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_REL: begin
                if (!sync_out) begin
                    state_d = ST_PEND_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PEND_PRESS: begin
                if (sync_out) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (sync_out) begin
                    state_d = ST_PEND_REL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PEND_REL: begin
                if (!sync_out) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_REL;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear wins over a same-cycle abort; increment saturates at 255.
    always_comb begin
        glitch_d = glitch_q;
        if (abort && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
        if (glitch_clr) begin
            glitch_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_REL;
            cnt_q    <= '0;
            clean_q  <= BTN_IDLE_LEVEL;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            glitch_q <= glitch_d;
        end
    end

    assign button_clean  = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign glitch_cnt    = glitch_q;

endmodule
